// File: rtl/pwm_duty_meter.sv
// Measures period and high time of a PWM waveform in clk cycles and reports the duty cycle
// in 10% steps, flagging inputs that stop toggling (stuck high or stuck low).
module pwm_duty_meter #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [3:0]       duty_step,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, STUCK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Largest k in 0..10 with k*per <= 10*hi; the comparisons are monotonic in k.
  function automatic logic [3:0] duty_of(input logic [CNT_W-1:0] per,
                                         input logic [CNT_W-1:0] hi);
    logic [CNT_W+3:0] hi10;
    logic [3:0]       k;
    hi10 = {4'b0, hi} * (CNT_W+4)'(10);
    k    = 4'd0;
    for (int i = 1; i <= 10; i++) begin
      if ((CNT_W+4)'(i) * {4'b0, per} <= hi10) k = 4'(i);
    end
    return k;
  endfunction

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p_q;
  logic                   s, rise, fall, timeout;
  logic [CNT_W-1:0]       per_ctr_q, per_ctr_d;
  logic [CNT_W-1:0]       hi_ctr_q, hi_ctr_d;
  logic [CNT_W-1:0]       idle_ctr_q, idle_ctr_d;
  logic                   stk_hi_q, stk_hi_d;
  logic                   stk_lo_q, stk_lo_d;
  logic                   go_stuck;

  logic [CNT_W-1:0]       cap_per_p0_q, cap_per_p0_d;
  logic [CNT_W-1:0]       cap_hi_p0_q, cap_hi_p0_d;
  logic                   frc_p0_q, frc_p0_d;
  logic [3:0]             frc_duty_p0_q, frc_duty_p0_d;
  logic                   vld_p0_q, vld_p0_d;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~p_q;
  assign fall    = ~s & p_q;
  // An edge on the timeout cycle means the input is still toggling.
  assign timeout = (idle_ctr_q >= TIMEOUT_C) && !rise && !fall;

  // ---- input synchronizer and edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      p_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      p_q    <= s;
    end
  end

  always_comb begin
    state_d       = state_q;
    per_ctr_d     = rise ? CNT_W'(1) : sat_inc(per_ctr_q);
    hi_ctr_d      = rise ? CNT_W'(1) : (s ? sat_inc(hi_ctr_q) : hi_ctr_q);
    idle_ctr_d    = (rise || fall) ? '0 : sat_inc(idle_ctr_q);
    stk_hi_d      = stk_hi_q;
    stk_lo_d      = stk_lo_q;
    cap_per_p0_d  = cap_per_p0_q;
    cap_hi_p0_d   = cap_hi_p0_q;
    frc_p0_d      = frc_p0_q;
    frc_duty_p0_d = frc_duty_p0_q;
    vld_p0_d      = 1'b0;
    go_stuck      = 1'b0;

    if (!enable) begin
      state_d    = IDLE;
      per_ctr_d  = '0;
      hi_ctr_d   = '0;
      idle_ctr_d = '0;
      stk_hi_d   = 1'b0;
      stk_lo_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = ARM;
          per_ctr_d  = '0;
          hi_ctr_d   = '0;
          idle_ctr_d = '0;
        end
        ARM: begin
          if (rise)         state_d  = MEASURE;
          else if (timeout) go_stuck = 1'b1;
        end
        MEASURE: begin
          if (rise) begin
            cap_per_p0_d = per_ctr_q;
            cap_hi_p0_d  = hi_ctr_q;
            frc_p0_d     = 1'b0;
            vld_p0_d     = 1'b1;
          end else if (timeout) begin
            go_stuck = 1'b1;
          end
        end
        STUCK: begin
          if (rise || fall) begin
            state_d  = rise ? MEASURE : ARM;
            stk_hi_d = 1'b0;
            stk_lo_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase

      // Single report per stuck episode: STUCK is left only on an edge.
      if (go_stuck) begin
        state_d       = STUCK;
        stk_hi_d      = s;
        stk_lo_d      = ~s;
        cap_per_p0_d  = '0;
        cap_hi_p0_d   = '0;
        frc_p0_d      = 1'b1;
        frc_duty_p0_d = s ? 4'd10 : 4'd0;
        vld_p0_d      = 1'b1;
      end
    end
  end

  // ---- p0: FSM, counters and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      per_ctr_q     <= '0;
      hi_ctr_q      <= '0;
      idle_ctr_q    <= '0;
      stk_hi_q      <= 1'b0;
      stk_lo_q      <= 1'b0;
      cap_per_p0_q  <= '0;
      cap_hi_p0_q   <= '0;
      frc_p0_q      <= 1'b0;
      frc_duty_p0_q <= '0;
      vld_p0_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      per_ctr_q     <= per_ctr_d;
      hi_ctr_q      <= hi_ctr_d;
      idle_ctr_q    <= idle_ctr_d;
      stk_hi_q      <= stk_hi_d;
      stk_lo_q      <= stk_lo_d;
      cap_per_p0_q  <= cap_per_p0_d;
      cap_hi_p0_q   <= cap_hi_p0_d;
      frc_p0_q      <= frc_p0_d;
      frc_duty_p0_q <= frc_duty_p0_d;
      vld_p0_q      <= vld_p0_d;
    end
  end

  // ---- p1: report registers
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      duty_step  <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= vld_p0_q;
      if (vld_p0_q) begin
        period_cnt <= cap_per_p0_q;
        high_cnt   <= cap_hi_p0_q;
        duty_step  <= frc_p0_q ? frc_duty_p0_q : duty_of(cap_per_p0_q, cap_hi_p0_q);
      end
    end
  end

  assign stuck_high = stk_hi_q;
  assign stuck_low  = stk_lo_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: table of PWM shapes plus stuck, enable and reset sequences.
module tb_pwm_duty_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        pwm_in = 1'b0;
  logic [15:0] period_cnt, high_cnt;
  logic [3:0]  duty_step;
  logic        meas_valid, stuck_high, stuck_low;

  pwm_duty_meter #(.CNT_W(16), .TIMEOUT(1000), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pwm_in(pwm_in),
    .period_cnt(period_cnt), .high_cnt(high_cnt), .duty_step(duty_step),
    .meas_valid(meas_valid), .stuck_high(stuck_high), .stuck_low(stuck_low)
  );

  always #5 clk = ~clk;

  typedef struct {int per; int hi; int exp_duty;} vec_t;
  vec_t vecs[15];

  int nchk = 0, npass = 0;
  int cur_per = 1, cur_hi = 0, ph = 0;
  int cyc = 0, nrep = 0, last_t = 0, prev_t = 0;
  int r_per = 0, r_hi = 0, r_duty = 0, r_sh = 0, r_sl = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic set_pat(input int p, input int h);
    cur_per = p; cur_hi = h; ph = 0;
  endtask

  // Drive one cycle of the waveform, then sample just after the edge.
  task automatic tick();
    pwm_in = (ph < cur_hi);
    ph = (ph + 1 == cur_per) ? 0 : ph + 1;
    @(posedge clk); #1;
    cyc++;
    if (meas_valid) begin
      nrep++;
      prev_t = last_t; last_t = cyc;
      r_per = int'(period_cnt); r_hi = int'(high_cnt); r_duty = int'(duty_step);
      r_sh = int'(stuck_high); r_sl = int'(stuck_low);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{10, 5, 5};
    for (int d = 1; d <= 9; d++) vecs[d] = '{10, d, d};
    vecs[10] = '{7, 3, 4};
    vecs[11] = '{2, 1, 5};
    vecs[12] = '{13, 4, 3};
    vecs[13] = '{20, 19, 9};
    vecs[14] = '{10, 5, 5};

    // Reset state
    set_pat(1, 0);
    run(3);
    chk("rst_period", int'(period_cnt), 0);
    chk("rst_high", int'(high_cnt), 0);
    chk("rst_duty", int'(duty_step), 0);
    chk("rst_valid", int'(meas_valid), 0);
    chk("rst_stuck", int'({stuck_high, stuck_low}), 0);
    rst = 1'b0;
    enable = 1'b1;
    run(2);

    // Table of PWM shapes, four periods each; last two reports must be clean
    for (int v = 0; v < 15; v++) begin
      set_pat(vecs[v].per, vecs[v].hi);
      nrep = 0;
      run(4 * vecs[v].per);
      chk($sformatf("v%0d_nrep_ge2", v), int'(nrep >= 2), 1);
      chk($sformatf("v%0d_period", v), r_per, vecs[v].per);
      chk($sformatf("v%0d_high", v), r_hi, vecs[v].hi);
      chk($sformatf("v%0d_duty", v), r_duty, vecs[v].exp_duty);
      chk($sformatf("v%0d_gap", v), last_t - prev_t, vecs[v].per);
    end

    // Enable dropped mid-period: no report, outputs hold, two rises needed after
    run(5);
    nrep = 0;
    enable = 1'b0;
    run(15);
    chk("dis_nrep", nrep, 0);
    chk("dis_hold_period", int'(period_cnt), 10);
    chk("dis_hold_duty", int'(duty_step), 5);
    enable = 1'b1;
    run(12);
    chk("reen_no_early_report", nrep, 0);
    run(10);
    chk("reen_nrep", nrep, 1);
    chk("reen_period", r_per, 10);
    chk("reen_duty", r_duty, 5);

    // Reset pulsed mid-measurement
    run(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_period", int'(period_cnt), 0);
    chk("midrst_duty", int'(duty_step), 0);
    chk("midrst_valid", int'(meas_valid), 0);
    nrep = 0;
    run(15);
    chk("midrst_no_early_report", nrep, 0);
    run(10);
    chk("midrst_nrep", nrep, 1);
    chk("midrst_report_period", r_per, 10);

    // Stuck low, then recovery
    do_reset();
    set_pat(1, 0);
    nrep = 0;
    run(1100);
    chk("sl_nrep", nrep, 1);
    chk("sl_flag", r_sl, 1);
    chk("sl_other_flag", r_sh, 0);
    chk("sl_duty", r_duty, 0);
    chk("sl_period", r_per, 0);
    chk("sl_high", r_hi, 0);
    chk("sl_flag_holds", int'(stuck_low), 1);
    set_pat(10, 5);
    nrep = 0;
    run(3);
    chk("sl_clear_on_rise", int'(stuck_low), 0);
    run(27);
    chk("sl_recover_nrep", nrep, 2);
    chk("sl_recover_period", r_per, 10);
    chk("sl_recover_high", r_hi, 5);
    chk("sl_recover_duty", r_duty, 5);

    // Stuck high, then fall to ARM and re-measure
    do_reset();
    set_pat(1, 0);
    run(5);
    set_pat(1, 1);
    nrep = 0;
    run(1100);
    chk("sh_nrep", nrep, 1);
    chk("sh_flag", r_sh, 1);
    chk("sh_other_flag", r_sl, 0);
    chk("sh_duty", r_duty, 10);
    chk("sh_period", r_per, 0);
    set_pat(1, 0);
    nrep = 0;
    run(6);
    chk("sh_clear_on_fall", int'({stuck_high, stuck_low}), 0);
    chk("sh_fall_no_report", nrep, 0);
    set_pat(10, 5);
    run(30);
    chk("sh_recover_nrep", nrep, 2);
    chk("sh_recover_period", r_per, 10);
    chk("sh_recover_duty", r_duty, 5);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
